// File: rtl/tt_um_seq_divider_if.sv
// Pin bundle of the sequential divider: operand/control inputs and result/status outputs.
interface tt_um_seq_divider_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_seq_divider.sv
// 8-bit restoring divider, one quotient bit per clock, 8-cycle run.
// Optional DIV_ZERO_FLAG_EN: divide-by-zero short-circuits to DONE and raises dz.
module tt_um_seq_divider (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_um_seq_divider_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t     state;
  logic [7:0] divisor, dvd, rem, q, r;
  logic [2:0] cnt;
  logic       start_d, ld_d, start_armed;
  logic       done, busy, dz;

  logic       start_p, ld_p, ge;
  logic [8:0] t, diff;
  logic [7:0] rem_nxt, dvd_nxt;
  logic       unused;

  // start must be seen low after reset before an edge on it counts
  always_comb begin
    start_p = bus.uio_in[0] & ~start_d & start_armed;
    ld_p    = bus.uio_in[5] & ~ld_d;
    t       = {rem, dvd[7]};
    diff    = t - {1'b0, divisor};
    ge      = (t >= {1'b0, divisor});
    rem_nxt = ge ? diff[7:0] : t[7:0];
    dvd_nxt = {dvd[6:0], ge};
  end

`ifdef DIV_ZERO_FLAG_EN
  logic [7:0] div_eff;
  // a divisor loaded on the same edge as start is the one that counts
  always_comb div_eff = ld_p ? bus.ui_in : divisor;
`else
  assign dz = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      divisor     <= '0;
      dvd         <= '0;
      rem         <= '0;
      q           <= '0;
      r           <= '0;
      cnt         <= '0;
      start_d     <= 1'b0;
      ld_d        <= 1'b0;
      start_armed <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz          <= 1'b0;
`endif
    end else begin
      start_d <= bus.uio_in[0];
      ld_d    <= bus.uio_in[5];
      if (!bus.uio_in[0]) start_armed <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (ld_p) divisor <= bus.ui_in;
          if (start_p) begin
            dvd  <= bus.ui_in;
            rem  <= '0;
            cnt  <= '0;
            done <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            if (div_eff == '0) begin
              q     <= '1;
              r     <= bus.ui_in;
              dz    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              dz    <= 1'b0;
              busy  <= 1'b1;
              state <= RUN;
            end
`else
            busy  <= 1'b1;
            state <= RUN;
`endif
          end
        end
        RUN: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            q     <= dvd_nxt;
            r     <= rem_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uo_out  = bus.uio_in[1] ? r : q;
  assign bus.uio_out = {3'b000, dz, done, busy, 2'b00};
  assign bus.uio_oe  = 8'b0001_1100;
  assign unused      = &{1'b0, bus.ena, bus.uio_in[7:6], bus.uio_in[4:2]};
endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Directed + randomized bench for tt_um_seq_divider against an arithmetic reference model.
module tb_tt_um_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  tt_um_seq_divider_if bus();
  tt_um_seq_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] d,
                                output logic [7:0] q, output logic [7:0] r);
    if (d == 8'd0) begin
      q = 8'hFF;
      r = a;
    end else begin
      q = a / d;
      r = a % d;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    bus.ui_in     = d;
    bus.uio_in[5] = 1'b1;
    step();
    bus.uio_in[5] = 1'b0;
    step();
  endtask

  task automatic check_result(input string tag, input logic [7:0] eq, input logic [7:0] er);
    bus.uio_in[1] = 1'b0;
    #1;
    check({tag, "_q"}, bus.uo_out, eq);
    bus.uio_in[1] = 1'b1;
    #1;
    check({tag, "_r"}, bus.uo_out, er);
    bus.uio_in[1] = 1'b0;
    #1;
  endtask

  // d is the divisor in effect; with_ld also pulses load_div on the start edge
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] d, input bit with_ld);
    logic [7:0] eq, er;
    int cycles;
    model(a, d, eq, er);
    bus.ui_in     = a;
    bus.uio_in[0] = 1'b1;
    bus.uio_in[5] = with_ld;
    step();
    bus.uio_in[0] = 1'b0;
    bus.uio_in[5] = 1'b0;
    bus.ui_in     = 8'($urandom);
`ifdef DIV_ZERO_FLAG_EN
    if (d == 8'd0) begin
      check({tag, "_dz_done"}, bus.uio_out[3], 1'b1);
      check({tag, "_dz_flag"}, bus.uio_out[4], 1'b1);
      check({tag, "_dz_busy"}, bus.uio_out[2], 1'b0);
      check_result(tag, eq, er);
      return;
    end
`endif
    check({tag, "_busy0"}, bus.uio_out[3:2], 2'b01);
    cycles = 0;
    while (bus.uio_out[3] !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
    check({tag, "_latency"}, cycles, 8);
    check({tag, "_status"}, bus.uio_out[4:2], 3'b010);
    check_result(tag, eq, er);
  endtask

  initial begin
    logic [7:0] a, d, eq, er;
    int restarts;
    bit seen_done;

    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    rst_n      = 1'b0;
    step(); step();
    check("rst_uo_out", bus.uo_out, 8'h00);
    check("rst_uio_out", bus.uio_out, 8'h00);
    check("uio_oe", bus.uio_oe, 8'h1C);
    rst_n = 1'b1;
    step(); step();

    do_load(8'd7);
    run_op("div_100_7", 8'd100, 8'd7, 1'b0);
    do_load(8'd1);
    run_op("div_255_1", 8'd255, 8'd1, 1'b0);
    do_load(8'd9);
    run_op("div_5_9", 8'd5, 8'd9, 1'b0);
    do_load(8'd255);
    run_op("div_255_255", 8'd255, 8'd255, 1'b0);
    do_load(8'd0);
    run_op("div_3c_0", 8'h3C, 8'd0, 1'b0);
    run_op("ld_with_start", 8'd50, 8'd50, 1'b1);

    // start held high through the run with a stray load pulse
    do_load(8'd13);
    bus.ui_in     = 8'd200;
    bus.uio_in[0] = 1'b1;
    step();
    check("held_busy", bus.uio_out[2], 1'b1);
    restarts  = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (i == 2) begin
        bus.ui_in     = 8'd3;
        bus.uio_in[5] = 1'b1;
      end
      if (i == 3) bus.uio_in[5] = 1'b0;
      step();
      if (bus.uio_out[3] === 1'b1) seen_done = 1'b1;
      else if (seen_done) restarts++;
    end
    check("held_restarts", restarts, 0);
    check("held_status", bus.uio_out[3:2], 2'b10);
    check_result("held", 8'd15, 8'd5);
    bus.uio_in[0] = 1'b0;
    step();
    run_op("div_kept", 8'd91, 8'd13, 1'b0);

    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      d = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_load(d);
      run_op($sformatf("rand%0d", i), a, d, 1'b0);
    end

    // reset in the middle of a run, start held high across release
    do_load(8'd9);
    bus.ui_in     = 8'd200;
    bus.uio_in[0] = 1'b1;
    step();
    bus.uio_in[0] = 1'b0;
    step(); step(); step();
    bus.uio_in[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_uo_out", bus.uo_out, 8'h00);
    check("midrst_uio_out", bus.uio_out, 8'h00);
    bus.uio_in[0] = 1'b1;
    step();
    rst_n = 1'b1;
    step(); step(); step();
    check("post_rst_no_start", bus.uio_out, 8'h00);
    check_result("post_rst_cleared", 8'h00, 8'h00);
    bus.uio_in[0] = 1'b0;
    step();
    do_load(8'd6);
    run_op("div_40_6", 8'd40, 8'd6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tt_um_seq_divider.md
TT_UM_SEQ_DIVIDER -- requirements
Module: tt_um_seq_divider

Interface
REQ-001 The module SHALL have no parameters; the operand width is fixed at 8 bits.
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
  clk      input   1  sole clock, rising-edge
  rst_n    input   1  reset, asynchronous, active-low
  ena      input   1  power-good, ignored
  ui_in    input   8  dividend on start; divisor on load_div
  uo_out   output  8  quotient when uio_in[1]=0, remainder when uio_in[1]=1
  uio_in   input   8  [0] start, [1] sel, [5] load_div; others ignored
  uio_out  output  8  [2] busy, [3] done, [4] dz (divide-by-zero); others 0
  uio_oe   output  8  constant 8'b0001_1100
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 start_p SHALL be uio_in[0] & ~start_d, where start_d is uio_in[0] registered each cycle.
REQ-005 ld_p SHALL be uio_in[5] & ~ld_d, where ld_d is uio_in[5] registered each cycle.
REQ-006 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-007 In IDLE or DONE, ld_p SHALL load divisor <= ui_in.
REQ-008 In IDLE or DONE, start_p SHALL perform, at that edge: dvd <= ui_in, rem <= 0, cnt <= 0, done <= 0, state <= RUN.
REQ-009 When ld_p and start_p occur at the same edge, the divisor SHALL load first, and the operation SHALL use the new divisor.
REQ-010 In RUN, each edge SHALL perform one restoring step:
  - t = {rem[7:0], dvd[7]} (9 bits), then dvd shifts left by one.
  - If t >= {1'b0, divisor}: rem <= t - divisor and the new dvd LSB is 1.
  - Otherwise: rem <= t[7:0] and the new dvd LSB is 0.
REQ-011 RUN SHALL last exactly 8 edges (cnt 0..7); on the 8th edge the FSM SHALL go to DONE and capture q <= quotient and r <= remainder.
REQ-012 busy SHALL be 1 while in RUN, i.e. for 8 cycles following the start edge.
REQ-013 done SHALL be 1 while in DONE and SHALL remain 1 until the next start_p or reset.
REQ-014 start_p and ld_p SHALL be ignored while in RUN; a level held high on start SHALL trigger exactly one operation.
REQ-015 uo_out SHALL be a combinational mux of the held q/r registers selected by sel; toggling sel SHALL never disturb state.
REQ-016 q and r SHALL keep their previous values during RUN and update only on entry to DONE.
REQ-017 divisor = 0 without DIV_ZERO_FLAG_EN SHALL yield q = 8'hFF and r = dividend after the normal 8-cycle run.

Reset
REQ-018 While rst_n = 0, the block SHALL hold: state = IDLE; q, r, rem, dvd, divisor, cnt, start_d, ld_d, done, busy, dz all 0.
REQ-019 Under reset, uo_out SHALL be 0 and uio_out SHALL be 0.
REQ-020 Reset asserted mid-RUN SHALL abort the operation immediately; no result SHALL be captured.
REQ-021 After reset release, start SHALL first be seen low before a new start_p can occur.

Configuration
REQ-022 With DIV_ZERO_FLAG_EN defined, start_p with divisor = 0 SHALL go directly to DONE at that same edge:
  - q <= 8'hFF, r <= ui_in, dz <= 1, busy never asserted.
  - dz SHALL clear on the next start_p.
REQ-023 Without DIV_ZERO_FLAG_EN, uio_out[4] SHALL be tied 0 and divisor = 0 SHALL follow REQ-017.

Verification
REQ-024 Load divisor 7, then start with ui_in = 100 -> busy for 8 cycles, done; uo_out = 14 with sel = 0 and 2 with sel = 1.
REQ-025 Divisor 1, dividend 255 -> q = 255, r = 0; divisor 9, dividend 5 -> q = 0, r = 5; divisor 255, dividend 255 -> q = 1, r = 0.
REQ-026 Divisor 0, dividend 0x3C:
  - With DIV_ZERO_FLAG_EN: done and dz one edge after start, q = 0xFF, r = 0x3C, busy stays 0.
  - Without DIV_ZERO_FLAG_EN: done after 8 cycles with the same q and r, dz = 0.
REQ-027 Start held high for 20 cycles, with ld/start pulses injected during RUN -> exactly one operation; divisor and result unaffected.
REQ-028 rst_n pulled low at RUN cycle 4 -> all outputs 0 at once, state IDLE, previous q and r cleared; a following 40/6 run gives q = 6, r = 4.
